cm0_acg_ctrl: RTL



---
 rtl/cm0_acg_ctrl_pkg.sv | 20 ++
 rtl/cm0_acg_ctrl_cnt.sv | 30 +++
 rtl/cm0_acg_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/cm0_acg_ctrl_pkg.sv
// Purpose: shared state encodings and counter sizing for the clock-enable sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cm0_acg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } acg_state_t;

    // Counter must hold the larger of the two load values.
    function automatic int acg_cnt_w(input int idle_cyc, input int wake_cyc);
        int mx;
        mx = (idle_cyc > wake_cyc) ? idle_cyc : wake_cyc;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/cm0_acg_ctrl_cnt.sv
// Purpose: loadable down-counter with an is-one flag for idle/settle timing.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; load has priority over decrement.
module cm0_acg_ctrl_cnt #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_is_one
);

    logic [W-1:0] r_cnt;

    // Counter register: reload wins over decrement, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_is_one = (r_cnt == W'(1));

endmodule

// File: rtl/cm0_acg_ctrl.sv
// Purpose: sequences the clock-gate ENABLE around core sleep requests with idle drain and wake settle.
// Latency: gating IDLE_CYC cycles after request with a quiet bus; wake done WAKE_CYC cycles after wake cause.
// Backpressure: BUSY restarts the idle window; WAKEUP/DBG_EN abort draining or end the gated period.
module cm0_acg_ctrl
    import cm0_acg_ctrl_pkg::*;
#(
    parameter int IDLE_CYC = 4,
    parameter int WAKE_CYC = 2
) (
    input  logic FCLK,
    input  logic HRESETn,
    input  logic SLEEP_REQ,
    input  logic BUSY,
    input  logic WAKEUP,
    input  logic DBG_EN,
    output logic GCLK_EN,
    output logic SLEEP_ACK,
    output logic WAKE_DONE
);

    localparam int CW = acg_cnt_w(IDLE_CYC, WAKE_CYC);

    acg_state_t      r_state;
    acg_state_t      w_nstate;
    logic            w_load;
    logic [CW-1:0]   w_load_val;
    logic            w_dec;
    logic            w_is_one;
    logic            w_stay_on;

    // Any of these keeps (or brings back) the gated domain clock.
    assign w_stay_on = WAKEUP | DBG_EN | ~SLEEP_REQ;

    cm0_acg_ctrl_cnt #(
        .W (CW)
    ) u_cnt (
        .i_clk      (FCLK),
        .i_rst_n    (HRESETn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_is_one   (w_is_one)
    );

    // Next-state and counter control; WAKE runs to completion regardless of inputs.
    always_comb begin
        w_nstate   = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (!w_stay_on) begin
                    w_nstate   = ST_DRAIN;
                    w_load     = 1'b1;
                    w_load_val = CW'(IDLE_CYC);
                end
            end
            ST_DRAIN: begin
                if (w_stay_on) begin
                    w_nstate = ST_RUN;
                end else if (BUSY) begin
                    w_load     = 1'b1;
                    w_load_val = CW'(IDLE_CYC);
                end else if (w_is_one) begin
                    w_nstate = ST_GATED;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GATED: begin
                if (w_stay_on) begin
                    w_nstate   = ST_WAKE;
                    w_load     = 1'b1;
                    w_load_val = CW'(WAKE_CYC);
                end
            end
            ST_WAKE: begin
                if (w_is_one) begin
                    w_nstate = ST_RUN;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_nstate = ST_RUN;
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from next state so they
    // change on the same edge as the state and never glitch.
    always_ff @(posedge FCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= ST_RUN;
            GCLK_EN   <= 1'b1;
            SLEEP_ACK <= 1'b0;
            WAKE_DONE <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            GCLK_EN   <= (w_nstate != ST_GATED);
            SLEEP_ACK <= (w_nstate == ST_GATED) || (w_nstate == ST_WAKE);
            WAKE_DONE <= (r_state == ST_WAKE) && (w_nstate == ST_RUN);
        end
    end

endmodule
